// File: rtl/xor_stream_pkg.sv
// Shared definitions for the XOR result stream: default sizing, the
// handshake-fire helper and the collector's flush state type.
//
// Handshake: a transfer happens on a rising CLK edge where en && rdy.
// A producer holding en with rdy low is stalled and keeps its data stable.
// A producer never withdraws en before the transfer completes.
// rdy may not depend combinationally on en.
package xor_stream_pkg;

  localparam int DEFAULT_WIDTH = 8;
  localparam int DEFAULT_DEPTH = 4;

  // Flush state of the collector: idle, or a partial word waiting for FIFO space
  typedef enum logic {
    FLUSH_IDLE    = 1'b0,
    FLUSH_PENDING = 1'b1
  } flush_state_e;

  // True on the cycle an en/rdy handshake completes
  function automatic logic hs_fire(input logic en, input logic rdy);
    return en && rdy;
  endfunction

endpackage

// File: rtl/sync_fifo_regs.sv
// Register-based synchronous FIFO: push/pop interface with a separate
// occupancy counter, so the pointers can wrap freely at DEPTH.
module sync_fifo_regs
  import xor_stream_pkg::*;
#(
  parameter  int WIDTH = DEFAULT_WIDTH,
  parameter  int DEPTH = DEFAULT_DEPTH,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count_q;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  // Head word comes straight from storage, so out_data is a register output
  assign head_data = mem[rd_ptr];

  // Storage: cleared on reset so the head reads zero while empty after reset
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (push_ok) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointers advance independently and wrap at DEPTH (power of two)
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + PTR_W'(1);
    end
  end

  // Occupancy: a simultaneous push and pop leaves it unchanged
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      count_q <= '0;
    end else begin
      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/xor_word_collector.sv
// Collects the 1-bit XOR result stream LSB-first into WIDTH-bit words,
// buffers finished words in a small FIFO and hands them on over en/rdy.
// A flush request pushes a partially filled word, zero-padded above the
// last collected bit. flush_busy mirrors the flush state register.
module xor_word_collector
  import xor_stream_pkg::*;
#(
  parameter  int WIDTH = DEFAULT_WIDTH,
  parameter  int DEPTH = DEFAULT_DEPTH,
  localparam int LVL_W = $clog2(DEPTH + 1)
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             in_data,
  input  logic             in_en,
  output logic             in_rdy,
  input  logic             flush,
  output logic [WIDTH-1:0] out_data,
  output logic             out_en,
  input  logic             out_rdy,
  output logic [LVL_W-1:0] level,
  output logic             flush_busy
);

  localparam int BC_W = $clog2(WIDTH);

  flush_state_e      flush_state_q;
  flush_state_e      flush_state_d;
  logic [BC_W-1:0]   bit_cnt_q;
  logic [BC_W-1:0]   bit_cnt_d;
  logic [WIDTH-1:0]  pack_q;
  logic [WIDTH-1:0]  pack_d;

  logic              last_bit;
  logic              in_fire;
  logic              out_fire;
  logic [WIDTH-1:0]  word_full;
  logic              fifo_push;
  logic [WIDTH-1:0]  fifo_push_data;
  logic              fifo_full;
  logic              fifo_empty;
  logic [LVL_W-1:0]  fifo_count;

  // The next accepted bit is the top bit of the current word
  assign last_bit = (bit_cnt_q == BC_W'(WIDTH - 1));

  // Ready depends on state only: blocked while a flush waits, or when the
  // completing bit would need a FIFO slot that is not there this cycle
  assign in_rdy   = (flush_state_q == FLUSH_IDLE) && !(last_bit && fifo_full);
  assign in_fire  = hs_fire(in_en, in_rdy);

  assign out_en   = !fifo_empty;
  assign out_fire = hs_fire(out_en, out_rdy);

  // Word completed by the incoming bit; the top bit of pack_q is always zero
  assign word_full = {in_data, pack_q[WIDTH-2:0]};

  assign level      = fifo_count;
  assign flush_busy = (flush_state_q == FLUSH_PENDING);

  // Packer and flush control: next state, next packing register and FIFO push
  always_comb begin
    flush_state_d  = flush_state_q;
    bit_cnt_d      = bit_cnt_q;
    pack_d         = pack_q;
    fifo_push      = 1'b0;
    fifo_push_data = pack_q;

    case (flush_state_q)
      FLUSH_IDLE: begin
        if (in_fire) begin
          if (last_bit) begin
            fifo_push      = 1'b1;
            fifo_push_data = word_full;
            bit_cnt_d      = '0;
            pack_d         = '0;
          end else begin
            pack_d[bit_cnt_q] = in_data;
            bit_cnt_d         = bit_cnt_q + BC_W'(1);
          end
        end
        // An empty partial word needs no flush; a completing bit already pushes
        if (flush && (bit_cnt_q != '0) && !(in_fire && last_bit)) begin
          flush_state_d = FLUSH_PENDING;
        end
      end

      FLUSH_PENDING: begin
        // Space is judged on the registered count; a same-cycle pop does not count
        if (!fifo_full) begin
          fifo_push      = 1'b1;
          fifo_push_data = pack_q;
          bit_cnt_d      = '0;
          pack_d         = '0;
          flush_state_d  = FLUSH_IDLE;
        end
      end

      default: begin
        flush_state_d = FLUSH_IDLE;
      end
    endcase
  end

  // Flush state register
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      flush_state_q <= FLUSH_IDLE;
    end else begin
      flush_state_q <= flush_state_d;
    end
  end

  // Partial word and its bit counter
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      bit_cnt_q <= '0;
      pack_q    <= '0;
    end else begin
      bit_cnt_q <= bit_cnt_d;
      pack_q    <= pack_d;
    end
  end

  sync_fifo_regs #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .push      (fifo_push),
    .push_data (fifo_push_data),
    .pop       (out_fire),
    .head_data (out_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

endmodule

// File: tb/tb_xor_word_collector.sv
// Bench for xor_word_collector: a queue-level model of the collector,
// a per-cycle compare process and directed scenarios with literal checks.
module tb_xor_word_collector;

  localparam int W  = 8;
  localparam int D  = 4;
  localparam int LW = $clog2(D + 1);

  // ---------------- clock / reset ----------------
  logic          CLK = 1'b0;
  logic          RST_N = 1'b0;
  logic          in_data = 1'b0;
  logic          in_en = 1'b0;
  logic          flush = 1'b0;
  logic          out_rdy = 1'b0;
  logic          in_rdy;
  logic [W-1:0]  out_data;
  logic          out_en;
  logic [LW-1:0] level;
  logic          flush_busy;

  always #5 CLK = ~CLK;

  xor_word_collector #(.WIDTH(W), .DEPTH(D)) dut (
    .CLK        (CLK),
    .RST_N      (RST_N),
    .in_data    (in_data),
    .in_en      (in_en),
    .in_rdy     (in_rdy),
    .flush      (flush),
    .out_data   (out_data),
    .out_en     (out_en),
    .out_rdy    (out_rdy),
    .level      (level),
    .flush_busy (flush_busy)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- model ----------------
  logic [W-1:0] exp_q[$];
  logic [W-1:0] m_pack;
  int           m_nbits;
  bit           m_pend;

  task automatic model_clear();
    exp_q.delete();
    m_pack  = '0;
    m_nbits = 0;
    m_pend  = 1'b0;
  endtask

  function automatic bit m_in_rdy();
    return !m_pend && !(m_nbits == W - 1 && exp_q.size() == D);
  endfunction

  always @(posedge CLK) begin : model_upd
    int           sz;
    bit           rdy;
    bit           pop;
    bit           push;
    bit           fire;
    logic [W-1:0] pw;
    if (!RST_N) begin
      model_clear();
    end else begin
      sz   = exp_q.size();
      rdy  = m_in_rdy();
      pop  = (sz != 0) && out_rdy;
      push = 1'b0;
      pw   = '0;
      if (m_pend) begin
        if (sz < D) begin
          push = 1'b1; pw = m_pack;
          m_pack = '0; m_nbits = 0; m_pend = 1'b0;
        end
      end else begin
        fire = in_en && rdy;
        if (flush && m_nbits != 0 && !(fire && m_nbits == W - 1)) m_pend = 1'b1;
        if (fire) begin
          m_pack[m_nbits] = in_data;
          m_nbits++;
          if (m_nbits == W) begin
            push = 1'b1; pw = m_pack;
            m_pack = '0; m_nbits = 0;
          end
        end
      end
      if (pop)  void'(exp_q.pop_front());
      if (push) exp_q.push_back(pw);
    end
  end

  // ---------------- scoreboard compare ----------------
  always @(negedge CLK) begin
    if (RST_N) begin
      chk("out_en",     out_en,     exp_q.size() != 0);
      chk("level",      level,      exp_q.size());
      chk("flush_busy", flush_busy, m_pend);
      chk("in_rdy",     in_rdy,     m_in_rdy());
      if (exp_q.size() != 0) chk("out_data", out_data, exp_q[0]);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cycle();
    @(negedge CLK);
    #1;
  endtask

  task automatic send_bit(input logic b);
    bit r;
    int n;
    n = 0;
    in_en   = 1'b1;
    in_data = b;
    do begin
      r = in_rdy;
      cycle();
      n++;
    end while (!r && n < 100);
    if (!r) begin
      checks++;
      errors++;
      $display("FAIL send_bit_timeout: in_rdy stuck low for %0d cycles", n);
    end
    in_en = 1'b0;
  endtask

  task automatic send_bits(input logic [W-1:0] v, input int n);
    for (int i = 0; i < n; i++) send_bit(v[i]);
  endtask

  task automatic send_word(input logic [W-1:0] v);
    send_bits(v, W);
  endtask

  task automatic pop_n(input int n);
    out_rdy = 1'b1;
    repeat (n) cycle();
    out_rdy = 1'b0;
  endtask

  task automatic pulse_flush();
    flush = 1'b1;
    cycle();
    flush = 1'b0;
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    errors++;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog");
  end

  // ---------------- directed scenarios ----------------
  initial begin
    model_clear();
    repeat (2) @(negedge CLK);
    #1;
    chk("rst_out_en",     out_en,     1'b0);
    chk("rst_out_data",   out_data,   8'h00);
    chk("rst_level",      level,      0);
    chk("rst_flush_busy", flush_busy, 1'b0);
    chk("rst_in_rdy",     in_rdy,     1'b1);
    RST_N = 1'b1;

    // 1: single word, consumer ready
    out_rdy = 1'b1;
    send_bit(1); send_bit(0); send_bit(1); send_bit(1);
    send_bit(0); send_bit(0); send_bit(1); send_bit(0);
    chk("t1_out_en",   out_en,   1'b1);
    chk("t1_out_data", out_data, 8'h4D);
    chk("t1_level1",   level,    1);
    cycle();
    chk("t1_level0",   level,    0);
    out_rdy = 1'b0;

    // 2: fill the FIFO and stall on the completing bit
    send_word(8'hA5); send_word(8'h3C); send_word(8'hF0); send_word(8'h81);
    chk("t2_level4", level, 4);
    send_bits(8'h5E, 7);
    chk("t2_in_rdy_low", in_rdy, 1'b0);
    in_en = 1'b1; in_data = 1'b0;
    repeat (3) cycle();
    chk("t2_stall_level", level, 4);
    chk("t2_head", out_data, 8'hA5);

    // 3: one-cycle pop frees space only after the edge
    out_rdy = 1'b1;
    cycle();
    out_rdy = 1'b0;
    chk("t3_level3", level, 3);
    chk("t3_in_rdy", in_rdy, 1'b1);
    chk("t3_head",   out_data, 8'h3C);
    cycle();
    in_en = 1'b0;
    chk("t3_level4", level, 4);
    pop_n(3);
    chk("t3_last_word", out_data, 8'h5E);
    pop_n(1);
    chk("t3_drained", level, 0);

    // 4: flush a 3-bit partial word
    send_bit(1); send_bit(1); send_bit(0);
    pulse_flush();
    chk("t4_busy",      flush_busy, 1'b1);
    chk("t4_in_rdy",    in_rdy,     1'b0);
    cycle();
    chk("t4_busy_done", flush_busy, 1'b0);
    chk("t4_level",     level,      1);
    chk("t4_word",      out_data,   8'h03);
    send_word(8'hC3);
    chk("t4_level2", level, 2);
    pop_n(1);
    chk("t4_fresh_word", out_data, 8'hC3);
    pop_n(1);

    // flush with nothing collected is ignored
    pulse_flush();
    chk("fl_empty_busy", flush_busy, 1'b0);
    chk("fl_empty_level", level, 0);

    // flush together with the completing bit: normal push, no pending flush
    send_bits(8'h7F, 7);
    in_en = 1'b1; in_data = 1'b1; flush = 1'b1;
    cycle();
    in_en = 1'b0; flush = 1'b0;
    chk("fl_cmp_busy", flush_busy, 1'b0);
    chk("fl_cmp_word", out_data,   8'hFF);
    pop_n(1);

    // flush together with a mid-word bit: that bit is included
    send_bit(1);
    in_en = 1'b1; in_data = 1'b1; flush = 1'b1;
    cycle();
    in_en = 1'b0; flush = 1'b0;
    chk("fl_mid_busy", flush_busy, 1'b1);
    cycle();
    chk("fl_mid_word", out_data, 8'h03);
    pop_n(1);

    // 5: flush while full waits for a pop
    send_word(8'h11); send_word(8'h22); send_word(8'h33); send_word(8'h44);
    send_bit(1); send_bit(0); send_bit(1); send_bit(0); send_bit(1);
    pulse_flush();
    chk("t5_busy", flush_busy, 1'b1);
    repeat (3) cycle();
    chk("t5_busy_held", flush_busy, 1'b1);
    chk("t5_in_rdy",    in_rdy,     1'b0);
    out_rdy = 1'b1;
    cycle();
    out_rdy = 1'b0;
    chk("t5_busy_after_pop", flush_busy, 1'b1);
    chk("t5_level3",         level,      3);
    cycle();
    chk("t5_busy_clear", flush_busy, 1'b0);
    chk("t5_level4",     level,      4);
    pop_n(3);
    chk("t5_last_word", out_data, 8'h15);
    pop_n(1);

    // 6: asynchronous reset mid-word with words buffered
    send_word(8'h66); send_word(8'h77);
    send_bit(1); send_bit(1); send_bit(1);
    chk("t6_level2", level, 2);
    RST_N = 1'b0;
    model_clear();
    #1;
    chk("t6_out_en",     out_en,     1'b0);
    chk("t6_level",      level,      0);
    chk("t6_flush_busy", flush_busy, 1'b0);
    chk("t6_in_rdy",     in_rdy,     1'b1);
    cycle();
    RST_N = 1'b1;
    send_word(8'h29);
    chk("t6_fresh_word", out_data, 8'h29);
    chk("t6_fresh_level", level, 1);
    pop_n(1);
    chk("t6_end_level", level, 0);

    cycle();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
